uart_rx_multi: RTL and testbench

- Second-generation UART receiver: configurable frame format, 16x oversampling with 3-sample majority vote, and a receive FIFO with a valid/ready drain port.
- Replaces the single-byte hold/accept receiver.
- Sits between the serial pin (via its internal synchroniser) and any byte consumer. Per-frame error flags are stored with each data word.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 54 +++++
 rtl/uart_rx_multi.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_multi.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and divisor helper for the multi-format UART receiver.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam logic [3:0]  TICK_S0    = 4'd7;
    localparam logic [3:0]  TICK_S1    = 4'd8;
    localparam logic [3:0]  TICK_S2    = 4'd9;
    localparam logic [3:0]  TICK_LAST  = 4'd15;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + baud * 8) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] fill
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [FW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign fill    = count;

    // Storage write; contents need no reset since head outputs are gated by valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_multi.sv
// UART receiver: 16x oversampling, 2-of-3 majority vote, configurable frame, receive FIFO.
module uart_rx_multi
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 27000000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 1,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_rx,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic [DATA_BITS-1:0]            o_data,
    output logic                            o_parity_err,
    output logic                            o_frame_err,
    output logic                            o_break,
    output logic                            o_overrun,
    input  logic                            i_clr_overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_fill
);
    localparam int unsigned DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned EW  = DATA_BITS + 3;

    if (DIV < 1) begin : g_div_err
        $error("uart_rx_multi: baud divisor below 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_err
        $error("uart_rx_multi: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE > PAR_ODD) begin : g_par_err
        $error("uart_rx_multi: PARITY_MODE must be 0..2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_err
        $error("uart_rx_multi: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_err
        $error("uart_rx_multi: FIFO_DEPTH must be a power of 2, at least 2");
    end

    rx_state_t            state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic [DW-1:0]        div_cnt;
    logic [3:0]           tick_cnt;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 smp7;
    logic                 smp8;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 par_err;
    logic                 frame_err;
    logic                 first_stop_low;
    logic                 overrun;

    logic                 tick;
    logic                 maj;
    logic                 decide;
    logic                 bit_end;
    logic                 exp_par;
    logic                 frame_push;
    logic [EW-1:0]        entry;
    logic [EW-1:0]        head;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign tick    = (state != StIdle) && (div_cnt == DW'(DIV - 1));
    // Third vote is the live tick-9 sample.
    assign maj     = (smp7 & smp8) | (smp7 & rx_sync) | (smp8 & rx_sync);
    assign decide  = tick && (tick_cnt == TICK_S2);
    assign bit_end = tick && (tick_cnt == TICK_LAST);
    assign exp_par = (^shift) ^ (PARITY_MODE == PAR_ODD);

    // Two-flop synchroniser, idling high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    // Frame FSM with tick divider, tick counter and sample capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= StIdle;
            div_cnt        <= '0;
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            stop_cnt       <= 1'b0;
            smp7           <= 1'b0;
            smp8           <= 1'b0;
            shift          <= '0;
            par_bit        <= 1'b0;
            par_err        <= 1'b0;
            frame_err      <= 1'b0;
            first_stop_low <= 1'b0;
        end else begin
            if (state == StIdle || tick) div_cnt <= '0;
            else                         div_cnt <= div_cnt + 1'b1;
            if (tick) begin
                tick_cnt <= tick_cnt + 1'b1;
                if (tick_cnt == TICK_S0) smp7 <= rx_sync;
                if (tick_cnt == TICK_S1) smp8 <= rx_sync;
            end
            case (state)
                StIdle: begin
                    tick_cnt  <= '0;
                    bit_cnt   <= '0;
                    stop_cnt  <= 1'b0;
                    par_err   <= 1'b0;
                    frame_err <= 1'b0;
                    if (!rx_sync) state <= StStart;
                end
                StStart: begin
                    if (decide && maj) state <= StIdle;
                    else if (bit_end)  state <= StData;
                end
                StData: begin
                    if (decide) shift <= {maj, shift[DATA_BITS-1:1]};
                    if (bit_end) begin
                        if (bit_cnt == 4'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_MODE != PAR_NONE) ? StParity : StStop;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (decide) begin
                        par_bit <= maj;
                        par_err <= maj ^ exp_par;
                    end
                    if (bit_end) state <= StStop;
                end
                StStop: begin
                    if (decide) begin
                        if (!maj)             frame_err      <= 1'b1;
                        if (stop_cnt == 1'b0) first_stop_low <= !maj;
                        // Leave on the last stop's decision so the next edge can resync.
                        if (stop_cnt == 1'(STOP_BITS - 1)) state <= StIdle;
                    end else if (bit_end) begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Frame entry assembled on the last stop bit's decision tick.
    always_comb begin
        logic first_low;
        logic brk;
        frame_push = (state == StStop) && decide && (stop_cnt == 1'(STOP_BITS - 1));
        first_low  = (stop_cnt == 1'b0) ? !maj : first_stop_low;
        brk        = (shift == '0) && ((PARITY_MODE == PAR_NONE) || !par_bit) && first_low;
        entry      = {brk, frame_err | !maj, par_err, shift};
    end

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (frame_push),
        .wdata (entry),
        .full  (fifo_full),
        .pop   (i_ready),
        .rdata (head),
        .empty (fifo_empty),
        .fill  (o_fill)
    );

    // Sticky overrun; a dropped frame outranks a same-cycle clear.
    always_ff @(posedge i_clk) begin
        if (i_rst)                                          overrun <= 1'b0;
        else if (frame_push && fifo_full && !(o_valid && i_ready)) overrun <= 1'b1;
        else if (i_clr_overrun)                             overrun <= 1'b0;
    end

    assign o_valid      = !fifo_empty;
    assign o_overrun    = overrun;
    assign o_data       = o_valid ? head[DATA_BITS-1:0] : '0;
    assign o_parity_err = o_valid & head[DATA_BITS];
    assign o_frame_err  = o_valid & head[DATA_BITS+1];
    assign o_break      = o_valid & head[DATA_BITS+2];

endmodule

// File: tb/tb_uart_rx_multi.sv
// Self-checking bench: an 8E1 receiver and a 7O2 receiver driven with generated serial frames.
module tb_uart_rx_multi;
    localparam int unsigned CLK_HZ = 7372800;
    localparam int unsigned BAUD   = 115200;
    // Clocks per bit: 16 oversample ticks of the rounded divisor (4 here).
    localparam int BIT_CYC  = ((CLK_HZ + BAUD * 8) / (BAUD * 16)) * 16;
    localparam int TICK_CYC = BIT_CYC / 16;
    // Falling edge to push edge: 2 sync flops + 1 cycle leaving idle, then ticks 0..9.
    localparam int PUSH_OFS = 3 + 10 * TICK_CYC;
    // Mid-bit sample offsets for ticks 7, 8, 9 are 8, 9, 10 ticks after bit start.
    localparam int T8_OFS   = 9 * TICK_CYC;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_b, ready_a, ready_b, clr_a, clr_b;
    logic       valid_a, pe_a, fe_a, brk_a, ovr_a;
    logic       valid_b, pe_b, fe_b, brk_b, ovr_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic [3:0] fill_a, fill_b;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_multi #(
        .CLK_FREQ_HZ (CLK_HZ), .BAUD_RATE (BAUD), .DATA_BITS (8),
        .PARITY_MODE (1), .STOP_BITS (1), .FIFO_DEPTH (8)
    ) dut_a (
        .i_clk (clk), .i_rst (rst), .i_rx (rx_a), .o_valid (valid_a), .i_ready (ready_a),
        .o_data (data_a), .o_parity_err (pe_a), .o_frame_err (fe_a), .o_break (brk_a),
        .o_overrun (ovr_a), .i_clr_overrun (clr_a), .o_fill (fill_a)
    );

    uart_rx_multi #(
        .CLK_FREQ_HZ (CLK_HZ), .BAUD_RATE (BAUD), .DATA_BITS (7),
        .PARITY_MODE (2), .STOP_BITS (2), .FIFO_DEPTH (8)
    ) dut_b (
        .i_clk (clk), .i_rst (rst), .i_rx (rx_b), .o_valid (valid_b), .i_ready (ready_b),
        .o_data (data_b), .o_parity_err (pe_b), .o_frame_err (fe_b), .o_break (brk_b),
        .o_overrun (ovr_b), .i_clr_overrun (clr_b), .o_fill (fill_b)
    );

    // Cycle in which o_valid was first seen high after being low.
    logic prev_va = 1'b0, prev_vb = 1'b0;
    int   rise_a = -1, rise_b = -1;
    always @(negedge clk) begin
        if (valid_a && !prev_va) rise_a <= cyc;
        if (valid_b && !prev_vb) rise_b <= cyc;
        prev_va <= valid_a;
        prev_vb <= valid_b;
    end

    typedef struct {
        logic [7:0]  data;
        logic        par_flip;
        logic        stop_low;
        logic [15:0] glitch;
        logic [7:0]  e_data;
        logic        e_pe;
        logic        e_fe;
        logic        e_brk;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    vec_t tbl [6];
    exp_t q [$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    // Builds a frame from its format and drives it bit by bit. glitch[b] inverts the line for
    // the single cycle sampled at tick 8 of bit b. push_ctl 1/2 raises ready_a/clr_a only in the
    // cycle ahead of the expected push edge. abort_bit pulses reset mid-bit and stops the frame.
    task automatic send(input int sel, input logic [8:0] data, input int dbits, input int pmode,
                        input int sbits, input logic par_flip, input logic stop_low,
                        input logic [15:0] glitch, input int abort_bit, input int push_ctl,
                        output int start_cyc, output int last_bit);
        logic [15:0] bits;
        logic        p;
        logic        hit;
        int          nb;
        bit          aborted;
        bits = '0;
        nb = 1;
        p = 1'b0;
        aborted = 1'b0;
        start_cyc = 0;
        for (int i = 0; i < dbits; i++) begin
            bits[nb] = data[i];
            p ^= data[i];
            nb++;
        end
        if (pmode != 0) begin
            bits[nb] = p ^ (pmode == 2) ^ par_flip;
            nb++;
        end
        for (int i = 0; i < sbits; i++) begin
            bits[nb] = !(stop_low && i == 0);
            nb++;
        end
        last_bit = nb - 1;
        for (int b = 0; b < nb && !aborted; b++) begin
            for (int t = 0; t < BIT_CYC && !aborted; t++) begin
                @(posedge clk);
                #1;
                if (b == 0 && t == 0) start_cyc = cyc;
                if (b == abort_bit && t == 20) begin
                    rst = 1'b1;
                    drive(sel, 1'b1);
                    @(posedge clk);
                    #1;
                    rst = 1'b0;
                    aborted = 1'b1;
                end else begin
                    drive(sel, bits[b] ^ (glitch[b] && t == T8_OFS));
                    hit = (b == last_bit) && (t == PUSH_OFS - 1);
                    if (push_ctl == 1) ready_a = hit;
                    if (push_ctl == 2) clr_a = hit;
                end
            end
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b1);
        ready_a = (push_ctl == 1) ? 1'b0 : ready_a;
        clr_a   = (push_ctl == 2) ? 1'b0 : clr_a;
    endtask

    // Waits (bounded) for the head entry, compares it, then pops it with a one-cycle ready.
    task automatic expect_pop(input int sel, input string name, input int d, input int pe,
                              input int fe, input int brk);
        int n;
        n = 0;
        @(negedge clk);
        while (!(sel == 0 ? valid_a : valid_b) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " valid"},  sel == 0 ? int'(valid_a) : int'(valid_b), 1);
        check({name, " data"},   sel == 0 ? int'(data_a)  : int'(data_b),  d);
        check({name, " par"},    sel == 0 ? int'(pe_a)    : int'(pe_b),    pe);
        check({name, " frame"},  sel == 0 ? int'(fe_a)    : int'(fe_b),    fe);
        check({name, " break"},  sel == 0 ? int'(brk_a)   : int'(brk_b),   brk);
        @(posedge clk);
        #1;
        if (sel == 0) ready_a = 1'b1;
        else          ready_b = 1'b1;
        @(posedge clk);
        #1;
        ready_a = 1'b0;
        ready_b = 1'b0;
    endtask

    initial begin
        int         st, lb;
        logic [7:0] d;
        logic       pf, sl, sp;
        logic [15:0] g;

        // Expected flags follow from what was put on the wire.
        tbl[0] = '{8'h55, 1'b0, 1'b0, 16'h0000, 8'h55, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'hA3, 1'b0, 1'b1, 16'h0000, 8'hA3, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{8'h0F, 1'b0, 1'b0, 16'h01FE, 8'h0F, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 1'b0, 16'h0000, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        ready_a = 1'b0; ready_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        idle(5);
        @(negedge clk);
        check("reset valid_a", valid_a, 0);
        check("reset fill_a", fill_a, 0);
        check("reset overrun_a", ovr_a, 0);
        check("reset data_a", data_a, 0);
        check("reset flags_a", {brk_a, fe_a, pe_a}, 0);
        check("reset valid_b", valid_b, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);

        // Table-driven 8E1 frames, one at a time into an empty FIFO.
        for (int i = 0; i < 6; i++) begin
            send(0, {1'b0, tbl[i].data}, 8, 1, 1, tbl[i].par_flip, tbl[i].stop_low,
                 tbl[i].glitch, -1, 0, st, lb);
            idle(80);
            check($sformatf("vec%0d fill", i), fill_a, 1);
            check($sformatf("vec%0d valid rise", i), rise_a, st + PUSH_OFS + BIT_CYC * lb);
            expect_pop(0, $sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_pe, tbl[i].e_fe,
                       tbl[i].e_brk);
        end

        // One-clock glitch and 16-clock (4-tick) pulse on an idle line: false starts.
        rx_a = 1'b0;
        idle(1);
        rx_a = 1'b1;
        idle(200);
        @(negedge clk);
        check("glitch fill", fill_a, 0);
        @(posedge clk);
        #1;
        rx_a = 1'b0;
        idle(4 * TICK_CYC);
        rx_a = 1'b1;
        idle(200);
        @(negedge clk);
        check("short pulse fill", fill_a, 0);
        check("short pulse valid", valid_a, 0);

        // 7O2 receiver: wrong parity, clean frame, break (parity bit 0 is wrong for odd).
        send(1, 9'h41, 7, 2, 2, 1'b1, 1'b0, 16'h0, -1, 0, st, lb);
        idle(40);
        check("7O2 fill", fill_b, 1);
        check("7O2 valid rise", rise_b, st + PUSH_OFS + BIT_CYC * lb);
        expect_pop(1, "7O2 bad parity", 8'h41, 1, 0, 0);
        send(1, 9'h41, 7, 2, 2, 1'b0, 1'b0, 16'h0, -1, 0, st, lb);
        idle(40);
        expect_pop(1, "7O2 clean", 8'h41, 0, 0, 0);
        send(1, 9'h00, 7, 2, 2, 1'b1, 1'b1, 16'h0, -1, 0, st, lb);
        idle(100);
        expect_pop(1, "7O2 break", 8'h00, 1, 1, 1);

        // Overrun: nine frames with ready low; the ninth is dropped.
        for (int i = 1; i <= 9; i++) begin
            send(0, 9'(i), 8, 1, 1, 1'b0, 1'b0, 16'h0, -1, 0, st, lb);
            idle(20);
        end
        @(negedge clk);
        check("overrun fill", fill_a, 8);
        check("overrun flag", ovr_a, 1);
        @(posedge clk);
        #1;
        clr_a = 1'b1;
        idle(1);
        clr_a = 1'b0;
        @(negedge clk);
        check("overrun cleared", ovr_a, 0);
        for (int i = 1; i <= 8; i++) expect_pop(0, $sformatf("drain%0d", i), i, 0, 0, 0);
        @(negedge clk);
        check("drained fill", fill_a, 0);

        // Full FIFO: clear coinciding with a dropped push loses to the set.
        for (int i = 0; i < 8; i++) begin
            send(0, 9'(8'h10 + i), 8, 1, 1, 1'b0, 1'b0, 16'h0, -1, 0, st, lb);
            idle(20);
        end
        send(0, 9'h20, 8, 1, 1, 1'b0, 1'b0, 16'h0, -1, 2, st, lb);
        idle(20);
        @(negedge clk);
        check("set beats clear", ovr_a, 1);
        @(posedge clk);
        #1;
        clr_a = 1'b1;
        idle(1);
        clr_a = 1'b0;
        // Full FIFO with a pop on the push cycle: both happen, no overrun.
        send(0, 9'h18, 8, 1, 1, 1'b0, 1'b0, 16'h0, -1, 1, st, lb);
        idle(20);
        @(negedge clk);
        check("full+pop fill", fill_a, 8);
        check("full+pop no overrun", ovr_a, 0);
        for (int i = 1; i <= 8; i++) begin
            expect_pop(0, $sformatf("fullpop%0d", i), 8'h10 + i, 0, 0, 0);
        end

        // Reset during data bit 4 abandons the frame.
        send(0, 9'hA5, 8, 1, 1, 1'b0, 1'b0, 16'h0, 5, 0, st, lb);
        idle(100);
        @(negedge clk);
        check("mid-frame reset fill", fill_a, 0);
        check("mid-frame reset valid", valid_a, 0);
        send(0, 9'hC3, 8, 1, 1, 1'b0, 1'b0, 16'h0, -1, 0, st, lb);
        idle(20);
        expect_pop(0, "after reset", 8'hC3, 0, 0, 0);

        // Random batches against a wire-level model of the frame.
        for (int batch = 0; batch < 4; batch++) begin
            q.delete();
            for (int k = 0; k < 4; k++) begin
                d  = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 7) == 0) d = 8'h00;
                pf = ($urandom_range(0, 3) == 0);
                sl = ($urandom_range(0, 5) == 0);
                g  = '0;
                g[$urandom_range(1, 8)] = 1'b1;
                send(0, {1'b0, d}, 8, 1, 1, pf, sl, g, -1, 0, st, lb);
                idle(60);
                sp = (^d) ^ pf;
                q.push_back('{d, sp != (^d), sl, (d == 8'h00) && !sp && sl});
            end
            @(negedge clk);
            check($sformatf("rand batch%0d fill", batch), fill_a, 4);
            for (int k = 0; k < 4; k++) begin
                expect_pop(0, $sformatf("rand%0d.%0d", batch, k), q[k].d, q[k].pe, q[k].fe,
                           q[k].brk);
            end
        end
        check("final overrun", ovr_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
